// File: rtl/ara_pkg.sv
// Shared lane types: element width, operand-queue indices and VRF read-latency defaults.
package ara_pkg;

  localparam int unsigned ELEN = 64;
  typedef logic [ELEN-1:0] elen_t;

  typedef enum logic [2:0] {
    AluA, AluB, MulFPUA, MulFPUB, MulFPUC, StA, SlideAddrGenA, MaskB
  } opq_e;

  localparam int unsigned NrOperandQueues = 8;
  typedef logic [$clog2(NrOperandQueues)-1:0] opq_idx_t;

  localparam int unsigned NrVrfBanks     = 8;
  localparam int unsigned VrfReadLatency = 1;

  // Worst case per queue: every bank granted on every cycle a read stays counted.
  typedef logic [$clog2(NrVrfBanks*(VrfReadLatency+1)+1)-1:0] inflight_cnt_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic opq_in_range(input opq_idx_t q);
    return int'(q) < int'(NrOperandQueues);
  endfunction

endpackage

// File: rtl/vrf_read_tag_pipe.sv
// Per-bank shift register of {valid, queue} tags covering the SRAM read latency.
module vrf_read_tag_pipe
  import ara_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     flush_i,
  input  logic     valid_i,
  input  opq_idx_t queue_i,
  output logic     valid_o,
  output opq_idx_t queue_o
);

  logic     [Depth-1:0] vld_pipe;
  opq_idx_t [Depth-1:0] queue_pipe;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_pipe   <= '0;
      queue_pipe <= '0;
    end else begin
      vld_pipe[0]   <= valid_i && !flush_i;
      queue_pipe[0] <= queue_i;
      for (int i = 1; i < Depth; i++) begin
        vld_pipe[i]   <= vld_pipe[i-1] && !flush_i;
        queue_pipe[i] <= queue_pipe[i-1];
      end
    end
  end

  assign valid_o = vld_pipe[Depth-1];
  assign queue_o = queue_pipe[Depth-1];

endmodule

// File: rtl/vrf_read_resp_stage.sv
// Routes VRF bank read data to the issuing operand queue after the fixed SRAM latency
// and keeps per-queue counts of reads that have been granted but not yet delivered.
module vrf_read_resp_stage
  import ara_pkg::*;
#(
  parameter int unsigned NrLanes        = 4,
  parameter int unsigned NrBanks        = 8,
  parameter int unsigned VrfReadLatency = ara_pkg::VrfReadLatency,
  localparam int unsigned CntW          = $clog2(NrBanks*(VrfReadLatency+1)+1)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    flush_i,
  input  logic [idx_width(NrLanes)-1:0]           lane_id_i,
  input  logic [NrBanks-1:0]                      bank_req_i,
  input  opq_idx_t [NrBanks-1:0]                  bank_req_queue_i,
  input  elen_t [NrBanks-1:0]                     bank_rdata_i,
  output elen_t [NrOperandQueues-1:0]             operand_o,
  output logic [NrOperandQueues-1:0]              operand_valid_o,
  output logic [NrOperandQueues-1:0][CntW-1:0]    inflight_cnt_o,
  output logic                                    collision_o
);

  localparam int unsigned HitW   = $clog2(NrBanks+1);
  localparam int unsigned BankW  = idx_width(NrBanks);
  localparam int          CntMax = int'(NrBanks*(VrfReadLatency+1));

  logic     [NrBanks-1:0]                    head_vld_p0;
  logic     [NrBanks-1:0]                    tail_vld;
  opq_idx_t [NrBanks-1:0]                    tail_queue;
  logic     [NrOperandQueues-1:0]            sel_vld;
  logic     [NrOperandQueues-1:0][BankW-1:0] sel_bank;
  logic     [NrOperandQueues-1:0][HitW-1:0]  hit_cnt;
  logic     [NrOperandQueues-1:0][HitW-1:0]  grant_cnt;
  logic     [NrOperandQueues-1:0][HitW-1:0]  ret_cnt_p1;
  logic                                      coll_now;

  // Stage p0: accepted grants enter the per-bank tag pipelines
  for (genvar b = 0; b < NrBanks; b++) begin : g_bank
    assign head_vld_p0[b] = bank_req_i[b] && opq_in_range(bank_req_queue_i[b]);

    vrf_read_tag_pipe #(.Depth(VrfReadLatency)) u_tag_pipe (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .valid_i (head_vld_p0[b]),
      .queue_i (bank_req_queue_i[b]),
      .valid_o (tail_vld[b]),
      .queue_o (tail_queue[b])
    );
  end

  // Descending scan so the lowest matching bank is the one left selected.
  always_comb begin
    sel_vld   = '0;
    sel_bank  = '0;
    hit_cnt   = '0;
    grant_cnt = '0;
    coll_now  = 1'b0;
    for (int q = 0; q < NrOperandQueues; q++) begin
      for (int b = NrBanks - 1; b >= 0; b--) begin
        if (tail_vld[b] && tail_queue[b] == opq_idx_t'(q)) begin
          sel_vld[q]  = 1'b1;
          sel_bank[q] = BankW'(b);
          hit_cnt[q]  = hit_cnt[q] + HitW'(1);
        end
        if (head_vld_p0[b] && bank_req_queue_i[b] == opq_idx_t'(q)) begin
          grant_cnt[q] = grant_cnt[q] + HitW'(1);
        end
      end
      if (hit_cnt[q] > HitW'(1)) coll_now = 1'b1;
    end
  end

  // Stage p1: operand registers; dropped collision reads retire alongside the winner
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      operand_o       <= '0;
      operand_valid_o <= '0;
      ret_cnt_p1      <= '0;
      inflight_cnt_o  <= '0;
      collision_o     <= 1'b0;
    end else if (flush_i) begin
      operand_valid_o <= '0;
      ret_cnt_p1      <= '0;
      inflight_cnt_o  <= '0;
    end else begin
      operand_valid_o <= sel_vld;
      ret_cnt_p1      <= hit_cnt;
      if (coll_now) collision_o <= 1'b1;
      for (int q = 0; q < NrOperandQueues; q++) begin
        if (sel_vld[q]) operand_o[q] <= bank_rdata_i[sel_bank[q]];
        inflight_cnt_o[q] <= inflight_cnt_o[q] + CntW'(grant_cnt[q]) - CntW'(ret_cnt_p1[q]);
      end
    end
  end

  collision_a : assert property (@(posedge clk_i) disable iff (rst_i) !(coll_now && !flush_i))
    else $warning("lane %0d: two banks returned to one operand queue", lane_id_i);

  for (genvar b = 0; b < NrBanks; b++) begin : g_range_chk
    queue_range_a : assert property (@(posedge clk_i) disable iff (rst_i)
      bank_req_i[b] |-> opq_in_range(bank_req_queue_i[b]))
      else $error("lane %0d: bank %0d read targets missing queue", lane_id_i, b);
  end

  for (genvar q = 0; q < NrOperandQueues; q++) begin : g_cnt_chk
    cnt_underflow_a : assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
      int'(inflight_cnt_o[q]) + int'(grant_cnt[q]) >= int'(ret_cnt_p1[q]))
      else $error("lane %0d: in-flight count underflow on queue %0d", lane_id_i, q);
    cnt_overflow_a : assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
      int'(inflight_cnt_o[q]) + int'(grant_cnt[q]) - int'(ret_cnt_p1[q]) <= CntMax)
      else $error("lane %0d: in-flight count overflow on queue %0d", lane_id_i, q);
  end

endmodule

// File: tb/tb_vrf_read_resp_stage.sv
// Bench for vrf_read_resp_stage: one instance per latency 1..3 on shared stimulus, each
// followed by a read-level scoreboard, plus directed scenarios.
module tb_vrf_read_resp_stage;
  import ara_pkg::*;

  localparam int NB = 8;
  localparam int NQ = NrOperandQueues;
  localparam int NL = 4;

  typedef struct packed { int due; int bank; int q; } rd_t;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                flush = 1'b0;
  logic [1:0]          lane_id = 2'd2;
  logic [NB-1:0]       bank_req = '0;
  opq_idx_t [NB-1:0]   bank_req_queue = '0;
  elen_t [NB-1:0]      bank_rdata = '0;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint unsigned got, input longint unsigned exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_lat
    localparam int unsigned L  = gi + 1;
    localparam int unsigned CW = $clog2(NB*(L+1)+1);

    elen_t [NQ-1:0]          operand;
    logic  [NQ-1:0]          operand_valid;
    logic  [NQ-1:0][CW-1:0]  cnt;
    logic                    collision;

    vrf_read_resp_stage #(.NrLanes(NL), .NrBanks(NB), .VrfReadLatency(L)) u_dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .flush_i          (flush),
      .lane_id_i        (lane_id),
      .bank_req_i       (bank_req),
      .bank_req_queue_i (bank_req_queue),
      .bank_rdata_i     (bank_rdata),
      .operand_o        (operand),
      .operand_valid_o  (operand_valid),
      .inflight_cnt_o   (cnt),
      .collision_o      (collision)
    );

    // Scoreboard of individual reads: each is delivered at its grant edge + L and
    // stops being counted one edge later.
    rd_t              pend[$];
    longint unsigned  m_data[NQ];
    bit               m_vld[NQ];
    int               m_cnt[NQ];
    bit               m_coll;
    int               edge_n;

    always @(posedge clk or posedge rst) begin
      int win[NQ];
      if (rst) begin
        pend.delete();
        m_coll = 1'b0;
        for (int q = 0; q < NQ; q++) begin
          m_data[q] = 0; m_vld[q] = 1'b0; m_cnt[q] = 0;
        end
      end else begin
        edge_n++;
        if (flush) begin
          pend.delete();
          for (int q = 0; q < NQ; q++) begin
            m_vld[q] = 1'b0; m_cnt[q] = 0;
          end
        end else begin
          for (int q = 0; q < NQ; q++) begin
            m_vld[q] = 1'b0; win[q] = NB;
          end
          for (int i = pend.size() - 1; i >= 0; i--) begin
            if (pend[i].due + 1 == edge_n) begin
              m_cnt[pend[i].q]--;
              pend.delete(i);
            end
          end
          foreach (pend[i]) begin
            if (pend[i].due == edge_n) begin
              if (m_vld[pend[i].q]) m_coll = 1'b1;
              m_vld[pend[i].q] = 1'b1;
              if (pend[i].bank < win[pend[i].q]) win[pend[i].q] = pend[i].bank;
            end
          end
          for (int q = 0; q < NQ; q++)
            if (m_vld[q]) m_data[q] = bank_rdata[win[q]];
          for (int b = 0; b < NB; b++) begin
            if (bank_req[b]) begin
              m_cnt[int'(bank_req_queue[b])]++;
              pend.push_back('{due: edge_n + int'(L), bank: b, q: int'(bank_req_queue[b])});
            end
          end
        end
      end
    end

    always @(negedge clk) begin
      if (chk_en) begin
        for (int q = 0; q < NQ; q++) begin
          check_val($sformatf("L%0d vld[%0d]", L, q), 64'(operand_valid[q]), 64'(m_vld[q]));
          check_val($sformatf("L%0d data[%0d]", L, q), 64'(operand[q]), m_data[q]);
          check_val($sformatf("L%0d cnt[%0d]", L, q), 64'(cnt[q]), 64'(m_cnt[q]));
        end
        check_val($sformatf("L%0d collision", L), 64'(collision), 64'(m_coll));
      end
    end
  end

  int t2_pulses = 0;
  int t2_peak   = 0;
  bit t2_mon    = 1'b0;

  always @(negedge clk) begin
    if (t2_mon) begin
      t2_pulses += $countones(g_lat[0].operand_valid);
      for (int q = 0; q < NQ; q++)
        if (int'(g_lat[0].cnt[q]) > t2_peak) t2_peak = int'(g_lat[0].cnt[q]);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #2;
    bank_req = '0;
    flush    = 1'b0;
    for (int b = 0; b < NB; b++) bank_rdata[b] = {$urandom, $urandom};
  endtask

  task automatic random_grants(input int pct);
    int perm[NB];
    for (int i = 0; i < NB; i++) perm[i] = i;
    for (int i = NB - 1; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(0, i));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int b = 0; b < NB; b++) begin
      bank_req[b]       = ($urandom_range(0, 99) < pct);
      bank_req_queue[b] = bank_req[b] ? opq_idx_t'(perm[b]) : opq_idx_t'($urandom_range(0, NQ-1));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Single read, bank 3 to AluA
    next_cycle();
    bank_req[3] = 1'b1; bank_req_queue[3] = opq_idx_t'(AluA);
    next_cycle();
    bank_rdata[3] = 64'hDEAD_BEEF;
    @(negedge clk);
    check_val("t1 cnt c+1", 64'(g_lat[0].cnt[AluA]), 64'd1);
    next_cycle();
    @(negedge clk);
    check_val("t1 vld", 64'(g_lat[0].operand_valid[AluA]), 64'd1);
    check_val("t1 data", 64'(g_lat[0].operand[AluA]), 64'hDEAD_BEEF);
    check_val("t1 cnt c+2", 64'(g_lat[0].cnt[AluA]), 64'd1);
    next_cycle();
    @(negedge clk);
    check_val("t1 cnt c+3", 64'(g_lat[0].cnt[AluA]), 64'd0);

    // All banks, one queue each, every cycle
    t2_mon = 1'b1;
    for (int c = 0; c < 20; c++) begin
      next_cycle();
      for (int b = 0; b < NB; b++) begin
        bank_req[b] = 1'b1; bank_req_queue[b] = opq_idx_t'(b);
      end
    end
    repeat (4) next_cycle();
    @(negedge clk);
    t2_mon = 1'b0;
    check_val("t2 pulses", 64'(t2_pulses), 64'd160);
    check_val("t2 peak", 64'(t2_peak), 64'd2);
    check_val("t2 coll", 64'(g_lat[0].collision), 64'd0);
    check_val("t2 cnt idle", 64'(g_lat[0].cnt != '0), 64'd0);

    // Banks 2 and 5 collide on MulFPUB
    next_cycle();
    bank_req[2] = 1'b1; bank_req_queue[2] = opq_idx_t'(MulFPUB);
    bank_req[5] = 1'b1; bank_req_queue[5] = opq_idx_t'(MulFPUB);
    next_cycle();
    bank_rdata[2] = 64'h2222_0000_AAAA_0002;
    bank_rdata[5] = 64'h5555_0000_BBBB_0005;
    next_cycle();
    @(negedge clk);
    check_val("t3 data", 64'(g_lat[0].operand[MulFPUB]), 64'h2222_0000_AAAA_0002);
    check_val("t3 coll", 64'(g_lat[0].collision), 64'd1);
    repeat (4) next_cycle();
    flush = 1'b1;
    repeat (2) next_cycle();
    @(negedge clk);
    check_val("t3 coll L1 post-flush", 64'(g_lat[0].collision), 64'd1);
    check_val("t3 coll L3 post-flush", 64'(g_lat[2].collision), 64'd1);
    check_val("t3 cnt", 64'(g_lat[0].cnt[MulFPUB]), 64'd0);

    // Latency 3: three grant cycles, the last one flushed
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      for (int b = 0; b < NB; b++) begin
        bank_req[b] = 1'b1; bank_req_queue[b] = opq_idx_t'(b);
      end
      if (c == 2) flush = 1'b1;
    end
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      @(negedge clk);
      check_val("t4 vld", 64'(g_lat[2].operand_valid), 64'd0);
      check_val("t4 cnt", 64'(g_lat[2].cnt != '0), 64'd0);
    end

    // Asynchronous reset in the middle of a burst
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      random_grants(80);
    end
    #1 rst = 1'b1;
    #1;
    check_val("t5 rst L1", 64'({g_lat[0].operand_valid != '0, g_lat[0].cnt != '0,
                                g_lat[0].operand != '0, g_lat[0].collision}), 64'd0);
    check_val("t5 rst L2", 64'({g_lat[1].operand_valid != '0, g_lat[1].cnt != '0,
                                g_lat[1].operand != '0, g_lat[1].collision}), 64'd0);
    check_val("t5 rst L3", 64'({g_lat[2].operand_valid != '0, g_lat[2].cnt != '0,
                                g_lat[2].operand != '0, g_lat[2].collision}), 64'd0);
    repeat (2) next_cycle();
    rst = 1'b0;
    bank_req[0] = 1'b1; bank_req_queue[0] = opq_idx_t'(AluB);
    next_cycle();
    bank_rdata[0] = 64'h0123_4567_89AB_CDEF;
    next_cycle();
    @(negedge clk);
    check_val("t5 first vld", 64'(g_lat[0].operand_valid[AluB]), 64'd1);
    check_val("t5 first data", 64'(g_lat[0].operand[AluB]), 64'h0123_4567_89AB_CDEF);

    // Random traffic with occasional flushes
    for (int c = 0; c < 10000; c++) begin
      next_cycle();
      random_grants(60);
      flush = ($urandom_range(0, 63) == 0);
    end
    repeat (6) next_cycle();
    @(negedge clk);
    #1;
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
